treasure_scheduler: RTL and testbench

TREASURE_SCHEDULER -- requirements
Module: treasure_scheduler

---
 rtl/treasure_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_treasure_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/treasure_scheduler.sv
// treasure_scheduler
//   Frame-synchronous detection scheduler. On a request it waits for a camera
//   frame boundary, discards SKIP_FRAMES frames while the image processor
//   settles, then collects NUM_FRAMES per-frame results. Each frame votes for
//   red and for one of three shapes. A colour or shape is reported only when
//   it collects at least VOTE_MIN votes.
//
//   Optional feature: define SCHED_TIMEOUT_EN to add a watchdog. The watchdog
//   aborts a detection stuck without frame boundaries for TIMEOUT_CYCLES
//   cycles, and reports ERR = 1 with TREASURE = 0.
//
// Ports
//   CLK       in   system clock, rising edge
//   RESET_N   in   synchronous active-low reset
//   VSYNC     in   camera frame sync, high at the frame boundary
//   REQ       in   detection request (level); ignored while BUSY
//   RESULT    in   [2:0] per-frame {shape[1:0], color}; color 1 = red, shape 0 = none
//   PROC_EN   out  image-processor counting enable (SKIP and COLLECT)
//   BUSY      out  high whenever not idle
//   DONE      out  one-cycle pulse qualifying TREASURE and ERR
//   TREASURE  out  [2:0] decided {shape, color}, held until the next DONE
//   ERR       out  watchdog abort flag, held until the next DONE
module treasure_scheduler #(
    parameter int NUM_FRAMES     = 5,
    parameter int SKIP_FRAMES    = 1,
    parameter int VOTE_MIN       = 3,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       VSYNC,
    input  logic       REQ,
    input  logic [2:0] RESULT,
    output logic       PROC_EN,
    output logic       BUSY,
    output logic       DONE,
    output logic [2:0] TREASURE,
    output logic       ERR
);

    generate
        if (NUM_FRAMES < 1 || NUM_FRAMES > 15 || SKIP_FRAMES < 0 || SKIP_FRAMES > 7 ||
            VOTE_MIN < 1 || VOTE_MIN > NUM_FRAMES || TIMEOUT_CYCLES < 1 ||
            TIMEOUT_CYCLES > 1048576) begin : g_bad_params
            $error("treasure_scheduler: parameter out of legal range");
        end
    endgenerate

    localparam logic [3:0] NUM_C  = 4'(NUM_FRAMES);
    localparam logic [3:0] SKIP_C = 4'(SKIP_FRAMES);
    localparam logic [3:0] VOTE_C = 4'(VOTE_MIN);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SKIP,
        COLLECT,
        DECIDE,
        REPORT
    } state_t;

    state_t state, state_n;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic       vs_d;
    logic       rise, fall;
    logic       smp_vld_p1;     // a COLLECT rise was seen last cycle; RESULT is valid now
    logic       smp_fire;
    logic [3:0] samp_cnt;
    logic [2:0] skip_cnt;
    logic [3:0] red_cnt;
    logic [3:0] shape_cnt [3:1];
    logic       tmo_fire;

    logic [1:0] shape_win;
    logic [3:0] shape_max;
    logic [1:0] shape_dec;
    logic       color_dec;
    logic [2:0] treasure_dec;

    assign rise     = VSYNC & ~vs_d;
    assign fall     = ~VSYNC & vs_d;
    assign smp_fire = smp_vld_p1 && (state == COLLECT);

    assign BUSY    = (state != IDLE);
    assign PROC_EN = (state == SKIP) || (state == COLLECT);
    assign DONE    = (state == REPORT);

    // Vote decision. Strict '>' keeps the lower shape code on a tie.
    always_comb begin
        shape_win = 2'd1;
        shape_max = shape_cnt[1];
        if (shape_cnt[2] > shape_max) begin
            shape_win = 2'd2;
            shape_max = shape_cnt[2];
        end
        if (shape_cnt[3] > shape_max) begin
            shape_win = 2'd3;
            shape_max = shape_cnt[3];
        end
        color_dec    = (red_cnt >= VOTE_C);
        shape_dec    = (shape_max >= VOTE_C) ? shape_win : 2'd0;
        treasure_dec = (shape_dec == 2'd0) ? 3'b000 : {shape_dec, color_dec};
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (REQ) state_n = SYNC;
            SYNC:    if (fall) state_n = (SKIP_FRAMES == 0) ? COLLECT : SKIP;
            SKIP:    if (rise && (({1'b0, skip_cnt} + 4'd1) == SKIP_C)) state_n = COLLECT;
            COLLECT: if (smp_fire && ((samp_cnt + 4'd1) == NUM_C)) state_n = DECIDE;
            DECIDE:  state_n = REPORT;
            REPORT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (tmo_fire) state_n = REPORT;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state        <= IDLE;
            vs_d         <= 1'b0;
            smp_vld_p1   <= 1'b0;
            samp_cnt     <= 4'd0;
            skip_cnt     <= 3'd0;
            red_cnt      <= 4'd0;
            shape_cnt[1] <= 4'd0;
            shape_cnt[2] <= 4'd0;
            shape_cnt[3] <= 4'd0;
            TREASURE     <= 3'b000;
        end else begin
            state      <= state_n;
            vs_d       <= VSYNC;
            smp_vld_p1 <= (state == COLLECT) && rise;

            if (state == IDLE && REQ) begin
                samp_cnt     <= 4'd0;
                skip_cnt     <= 3'd0;
                red_cnt      <= 4'd0;
                shape_cnt[1] <= 4'd0;
                shape_cnt[2] <= 4'd0;
                shape_cnt[3] <= 4'd0;
            end else begin
                if (state == SKIP && rise) skip_cnt <= skip_cnt + 3'd1;
                if (smp_fire) begin
                    samp_cnt <= sat_inc(samp_cnt);
                    if (RESULT[0]) red_cnt <= sat_inc(red_cnt);
                    case (RESULT[2:1])
                        2'd1:    shape_cnt[1] <= sat_inc(shape_cnt[1]);
                        2'd2:    shape_cnt[2] <= sat_inc(shape_cnt[2]);
                        2'd3:    shape_cnt[3] <= sat_inc(shape_cnt[3]);
                        default: ;
                    endcase
                end
            end

            // Output latched on REPORT entry, so it is valid together with DONE.
            if (state == DECIDE) TREASURE <= treasure_dec;
            else if (tmo_fire)   TREASURE <= 3'b000;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    // Watchdog. tmo_hit acts as the carry out of the 20-bit counter, so a
    // limit of 2^20 is reachable. The abort lands exactly TIMEOUT_CYCLES+1
    // cycles after the last clear.
    logic [19:0] tmo_cnt;
    logic        tmo_hit;

    assign tmo_fire = tmo_hit && ((state == SYNC) || (state == SKIP) || (state == COLLECT));

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            tmo_cnt <= 20'd0;
            tmo_hit <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            if (state == IDLE || rise) begin
                tmo_cnt <= 20'd0;
                tmo_hit <= 1'b0;
            end else if (!tmo_hit) begin
                tmo_cnt <= tmo_cnt + 20'd1;
                tmo_hit <= (tmo_cnt == 20'(TIMEOUT_CYCLES - 1));
            end
            if (state == DECIDE) ERR <= 1'b0;
            else if (tmo_fire)   ERR <= 1'b1;
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_treasure_scheduler.sv
// Bench for treasure_scheduler with default voting parameters.
// A watchdog limit of 100 is used when SCHED_TIMEOUT_EN is defined.
module tb_treasure_scheduler;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       VSYNC = 1'b0;
    logic       REQ = 1'b0;
    logic [2:0] RESULT = 3'b000;
    logic       PROC_EN, BUSY, DONE, ERR;
    logic [2:0] TREASURE;

    treasure_scheduler #(
        .NUM_FRAMES(5), .SKIP_FRAMES(1), .VOTE_MIN(3), .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .VSYNC(VSYNC), .REQ(REQ), .RESULT(RESULT),
        .PROC_EN(PROC_EN), .BUSY(BUSY), .DONE(DONE), .TREASURE(TREASURE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    logic [3:0] exp_q [$];   // {ERR, TREASURE} expected per DONE

    always @(posedge CLK) if (RESET_N && DONE === 1'b1) done_seen++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // One camera frame: body low, then VSYNC high for two cycles. RESULT carries
    // a decoy on the rise cycle and the real value only on the cycle after it.
    task automatic frame(input logic [2:0] r);
        VSYNC = 1'b0; RESULT = r ^ 3'b111; tick(6);
        VSYNC = 1'b1; tick(1);
        RESULT = r; tick(1);
        RESULT = r ^ 3'b111;
    endtask

    task automatic preamble();
        VSYNC = 1'b1; tick(2);
    endtask

    task automatic start_req();
        REQ = 1'b1; tick(1); REQ = 1'b0;
    endtask

    task automatic wait_done(output bit ok, output int cycles);
        VSYNC = 1'b0;
        cycles = 0;
        while (DONE !== 1'b1 && cycles < 400) begin
            tick(1);
            cycles++;
        end
        ok = (DONE === 1'b1);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; REQ = 1'b1; VSYNC = 1'b1;
        tick(3);
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", DONE); end
        checks++; if (PROC_EN !== 1'b0) begin failures++; $display("FAIL reset_proc_en: got %b want 0", PROC_EN); end
        checks++; if (TREASURE !== 3'b000) begin failures++; $display("FAIL reset_treasure: got %b want 000", TREASURE); end
        checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", ERR); end
        REQ = 1'b0; VSYNC = 1'b0; RESET_N = 1'b1;
        tick(2);
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL idle_after_reset: busy got %b want 0", BUSY); end
    endtask

    task automatic test_basic();
        bit ok; int cyc; logic [3:0] exp;
        start_req();
        checks++; if (BUSY !== 1'b1 || PROC_EN !== 1'b0) begin failures++; $display("FAIL sync_state: busy=%b proc_en=%b want busy=1 proc_en=0", BUSY, PROC_EN); end
        REQ = 1'b1; tick(1); REQ = 1'b0;   // ignored while busy
        preamble();
        frame(3'b101);
        checks++; if (PROC_EN !== 1'b1) begin failures++; $display("FAIL collect_proc_en: got %b want 1", PROC_EN); end
        for (int i = 0; i < 5; i++) frame(3'b101);
        exp_q.push_back(4'b0101);
        wait_done(ok, cyc);
        exp = exp_q.pop_front();
        checks++; if (!ok || {ERR, TREASURE} !== exp) begin failures++; $display("FAIL basic_101: got done=%b err=%b treasure=%b, want err=%b treasure=%b", ok, ERR, TREASURE, exp[3], exp[2:0]); end
        tick(1);
        checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL done_pulse_width: done=%b busy=%b want 0 0", DONE, BUSY); end
    endtask

    task automatic test_votes();
        logic [2:0] pat [4][5];
        logic [2:0] res [4];
        bit ok; int cyc; logic [3:0] exp;
        pat[0] = '{3'b011, 3'b011, 3'b101, 3'b100, 3'b011}; res[0] = 3'b011;
        pat[1] = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b110}; res[1] = 3'b000;
        pat[2] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001}; res[2] = 3'b000;
        pat[3] = '{3'b110, 3'b100, 3'b100, 3'b110, 3'b111}; res[3] = 3'b110;
        for (int t = 0; t < 4; t++) begin
            start_req();
            preamble();
            frame(3'b111);                 // discarded
            for (int i = 0; i < 5; i++) frame(pat[t][i]);
            exp_q.push_back({1'b0, res[t]});
            wait_done(ok, cyc);
            exp = exp_q.pop_front();
            checks++; if (!ok || {ERR, TREASURE} !== exp) begin failures++; $display("FAIL votes_%0d: got done=%b err=%b treasure=%b, want err=%b treasure=%b", t, ok, ERR, TREASURE, exp[3], exp[2:0]); end
            tick(2);
        end
    endtask

    task automatic test_reset_abort();
        bit ok; int cyc; int d0; logic [3:0] exp;
        start_req();
        preamble();
        frame(3'b011);
        frame(3'b011);
        frame(3'b011);
        VSYNC = 1'b0; RESULT = 3'b011; tick(3);   // inside 3rd voted frame
        RESET_N = 1'b0; tick(1);
        checks++; if (BUSY !== 1'b0 || PROC_EN !== 1'b0) begin failures++; $display("FAIL abort_idle: busy=%b proc_en=%b want 0 0", BUSY, PROC_EN); end
        checks++; if (TREASURE !== 3'b000) begin failures++; $display("FAIL abort_treasure: got %b want 000", TREASURE); end
        RESET_N = 1'b1;
        d0 = done_seen;
        VSYNC = 1'b1; tick(3); VSYNC = 1'b0; tick(20);
        checks++; if (done_seen !== d0) begin failures++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen - d0); end
        // Stale votes would turn this into 011.
        start_req();
        preamble();
        frame(3'b000);
        frame(3'b011);
        for (int i = 0; i < 4; i++) frame(3'b000);
        exp_q.push_back(4'b0000);
        wait_done(ok, cyc);
        exp = exp_q.pop_front();
        checks++; if (!ok || {ERR, TREASURE} !== exp) begin failures++; $display("FAIL restart_clean: got done=%b err=%b treasure=%b, want err=%b treasure=%b", ok, ERR, TREASURE, exp[3], exp[2:0]); end
        tick(2);
    endtask

`ifdef SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok; int cyc; logic [3:0] exp;
        start_req();
        exp_q.push_back(4'b1000);
        wait_done(ok, cyc);
        exp = exp_q.pop_front();
        checks++; if (!ok || cyc != 101) begin failures++; $display("FAIL timeout_latency: got done=%b after %0d cycles want 101", ok, cyc); end
        checks++; if ({ERR, TREASURE} !== exp) begin failures++; $display("FAIL timeout_flags: got err=%b treasure=%b want err=1 treasure=000", ERR, TREASURE); end
        tick(2);
    endtask
`endif

    task automatic test_back_to_back();
        bit ok; int cyc; logic [3:0] exp;
        logic [2:0] pat [5];
        pat = '{3'b111, 3'b111, 3'b110, 3'b000, 3'b000};
        REQ = 1'b1; tick(1);
        preamble();
        for (int i = 0; i < 6; i++) frame(3'b011);
        exp_q.push_back(4'b0011);
        wait_done(ok, cyc);
        exp = exp_q.pop_front();
        checks++; if (!ok || {ERR, TREASURE} !== exp) begin failures++; $display("FAIL b2b_first: got done=%b err=%b treasure=%b, want err=%b treasure=%b", ok, ERR, TREASURE, exp[3], exp[2:0]); end
        tick(1);
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap: busy got %b want 0", BUSY); end
        tick(1);
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL b2b_restart: busy got %b want 1", BUSY); end
        preamble();
        REQ = 1'($urandom_range(0, 1));
        frame(3'b000);
        for (int i = 0; i < 5; i++) begin
            REQ = (i == 4) ? 1'b0 : 1'($urandom_range(0, 1));
            frame(pat[i]);
        end
        exp_q.push_back(4'b0110);
        wait_done(ok, cyc);
        exp = exp_q.pop_front();
        checks++; if (!ok || {ERR, TREASURE} !== exp) begin failures++; $display("FAIL b2b_second: got done=%b err=%b treasure=%b, want err=%b treasure=%b", ok, ERR, TREASURE, exp[3], exp[2:0]); end
        tick(2);
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL b2b_stop: busy got %b want 0", BUSY); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_votes();
        test_reset_abort();
`ifdef SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
